// File: rtl/siso_shift_arbiter_if.sv
// Requester-side bundle for the round-robin serial shift-out arbiter.
// master = requester/bench side, slave = arbiter side.
interface siso_shift_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic                  serial_out;
    logic                  frame;
    logic                  busy;
    logic                  done;

    modport master (
        output req, data_in,
        input  gnt, serial_out, frame, busy, done
    );

    modport slave (
        input  req, data_in,
        output gnt, serial_out, frame, busy, done
    );
endinterface

// File: rtl/siso_shift_arbiter.sv
// Round-robin arbiter that shifts the granted requester's word out MSB-first with a frame strobe.
// Latency: gnt + MSB one cycle after req is seen in IDLE; optional even-parity bit under SISO_ARB_PARITY_EN.
// Backpressure: none; req is held until gnt and is ignored while a frame is in flight.
module siso_shift_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    siso_shift_arbiter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SISO_ARB_PARITY_EN
    localparam logic [1:0] S_PAR   = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
`ifdef SISO_ARB_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             found;
    logic [PW-1:0]    win;
    logic [WIDTH-1:0] win_word;
    int               j;

    // First pending request at or above ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
        win_word = bus.data_in[int'(win)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
`ifdef SISO_ARB_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    sr_d    = win_word;
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << win;
                    ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
`ifdef SISO_ARB_PARITY_EN
                    par_d   = ^win_word;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
`ifdef SISO_ARB_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SISO_ARB_PARITY_EN
            S_PAR:   state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
`ifdef SISO_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
`ifdef SISO_ARB_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only, so req/data_in never reach them combinationally.
    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
`ifdef SISO_ARB_PARITY_EN
    assign bus.frame      = (state_q == S_SHIFT) || (state_q == S_PAR);
    assign bus.serial_out = (state_q == S_SHIFT) ? sr_q[WIDTH-1] :
                            (state_q == S_PAR)   ? par_q : 1'b0;
`else
    assign bus.frame      = (state_q == S_SHIFT);
    assign bus.serial_out = (state_q == S_SHIFT) ? sr_q[WIDTH-1] : 1'b0;
`endif
endmodule

// File: tb/tb_siso_shift_arbiter.sv
// Directed bench for siso_shift_arbiter with a frame-level expectation queue checked every cycle.
// Build with +define+SISO_ARB_PARITY_EN to exercise the parity variant.
module tb_siso_shift_arbiter;
    localparam int W = 4;
    localparam int N = 4;
`ifdef SISO_ARB_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    siso_shift_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    siso_shift_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         ser;
        logic         frm;
        logic         bsy;
        logic         dn;
    } obs_t;

    obs_t expq[$];
    int   mptr;
    logic [3:0] exp_g [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whenever no frame is outstanding, a nonzero req at an edge starts a whole frame:
    // WIDTH data bits (grant on the first), optional parity, one done cycle, one idle cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expq.delete();
            mptr = 0;
        end else if (expq.size() == 0 && bus.req != '0) begin
            int w;
            logic [W-1:0] word;
            obs_t e;
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && bus.req[(mptr + i) % N]) w = (mptr + i) % N;
            word = bus.data_in[w*W +: W];
            for (int k = 0; k < W; k++) begin
                e     = '0;
                e.gnt = (k == 0) ? (N'(1) << w) : '0;
                e.ser = word[W-1-k];
                e.frm = 1'b1;
                e.bsy = 1'b1;
                expq.push_back(e);
            end
`ifdef SISO_ARB_PARITY_EN
            e     = '0;
            e.ser = ^word;
            e.frm = 1'b1;
            e.bsy = 1'b1;
            expq.push_back(e);
`endif
            e     = '0;
            e.bsy = 1'b1;
            e.dn  = 1'b1;
            expq.push_back(e);
            e = '0;
            expq.push_back(e);
            mptr = (w + 1) % N;
        end
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (expq.size() > 0) e = expq.pop_front();
        else                 e = '0;
        a = {bus.gnt, bus.serial_out, bus.frame, bus.busy, bus.done};
        chk("cycle_model", 32'(a), 32'(e));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 40 && !idle; c++) begin
            tick();
            if (!bus.busy) idle = 1'b1;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] bits;
        logic [W:0] fb;
        int gl[$];
        int gt[$];
        int nb, dc, g3;

        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = {4'b0111, 4'b1100, 4'b0110, 4'b1011};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({bus.gnt, bus.serial_out, bus.frame, bus.busy, bus.done}), 32'd0);
        rst = 1'b0;

        // Single frame from requester 0, word 1011.
        tick();
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        bits[3] = bus.serial_out;
        bus.req = '0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_frame", 32'({bus.frame, bus.gnt}), 32'h10);
            bits[3-k] = bus.serial_out;
        end
        chk("t1_bits", 32'(bits), 32'hB);
`ifdef SISO_ARB_PARITY_EN
        tick();
        chk("t1_par_bit", 32'({bus.frame, bus.serial_out}), 32'h3);
`endif
        tick();
        chk("t1_done", 32'({bus.done, bus.frame, bus.serial_out}), 32'h4);
        tick();
        chk("t1_idle", 32'({bus.busy, bus.done}), 32'h0);

        // All four requesting after a reset: rotation starts at 0.
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.req = 4'b1111;
        for (int c = 0; c < 60 && gl.size() < 5; c++) begin
            tick();
            if (bus.gnt != '0) begin
                gl.push_back(int'(bus.gnt));
                gt.push_back(c);
            end
        end
        bus.req = '0;
        chk("t2_ngrants", 32'(gl.size()), 32'd5);
        for (int i = 0; i < gl.size(); i++) chk("t2_order", 32'(gl[i]), 32'(exp_g[i]));
        for (int i = 1; i < gl.size(); i++) chk("t2_period", 32'(gt[i] - gt[i-1]), 32'(FLEN + 2));
        wait_idle();

        // ptr sits at 1: req 0101 grants 2 before 0.
        gl.delete();
        bus.req = 4'b0101;
        for (int c = 0; c < 40 && gl.size() < 2; c++) begin
            tick();
            if (bus.gnt != '0) begin
                gl.push_back(int'(bus.gnt));
                bus.req = bus.req & ~bus.gnt;
            end
        end
        chk("t3_ngrants", 32'(gl.size()), 32'd2);
        if (gl.size() == 2) begin
            chk("t3_first", 32'(gl[0]), 32'h4);
            chk("t3_second", 32'(gl[1]), 32'h1);
        end
        wait_idle();

        // Asynchronous reset during the second bit of a frame.
        bus.req = 4'b0001;
        tick();
        chk("t4_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_async", 32'({bus.gnt, bus.serial_out, bus.frame, bus.busy, bus.done}), 32'd0);
        bus.req = 4'b0010;
        tick();
        chk("t4_rst_held", 32'({bus.gnt, bus.serial_out, bus.frame, bus.busy, bus.done}), 32'd0);
        rst = 1'b0;
        tick();
        chk("t4_gnt_after_rst", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        wait_idle();

        // Requester 3, word 0111: bit order, parity and done offset.
        bus.req = 4'b1000;
        tick();
        chk("t5_gnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        fb = '0;
        nb = 0;
        dc = -1;
        for (int c = 0; c < FLEN + 4; c++) begin
            if (c > 0) tick();
            if (bus.frame) begin
                fb = {fb[W-1:0], bus.serial_out};
                nb++;
            end
            if (bus.done && dc < 0) dc = c;
        end
        chk("t5_nbits", 32'(nb), 32'(FLEN));
`ifdef SISO_ARB_PARITY_EN
        chk("t5_bits", 32'(fb), 32'h0F);
`else
        chk("t5_bits", 32'(fb), 32'h07);
`endif
        chk("t5_done_offset", 32'(dc), 32'(FLEN));
        wait_idle();

        // req[3] pulses mid-frame and is gone before IDLE: never granted.
        bus.req = 4'b0001;
        tick();
        chk("t6_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        tick();
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        g3 = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.gnt[3]) g3++;
        end
        chk("t6_no_gnt3", 32'(g3), 32'd0);
        chk("t6_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
